muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit that sits directly upstream of the 32-entry GPR file.
- Accepts one M-extension operation with rs1/rs2 operand values and the destination register index, then computes the result over multiple cycles.
- Emits a single-cycle write-back beat (enable/address/data) that connects straight to the GPR file write port.
- Asserts busy so issue logic stalls while an operation is in flight.

---
 rtl/rv32m_defs.sv | 26 ++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_defs.sv
// Purpose: shared RV32M definitions for the iterative multiply/divide unit:
//          operand width, iteration count, funct3 op codes and FSM states.
// Ports:   none (package).
package rv32m_defs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = $clog2(ITERS);
  localparam int unsigned RF_AW = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// Purpose: one combinational iteration of the multiply/divide datapath.
// Ports:   i_div_mode - 0: shift-add multiply step, 1: restoring divide step
//          i_acc      - upper accumulator (product high / partial remainder)
//          i_part     - partial operand (multiplier+product low / dividend+quotient)
//          i_opnd     - multiplicand or divisor
//          o_acc      - next accumulator
//          o_part     - next partial operand
module muldiv_step
  import rv32m_defs::*;
(
  input  logic            i_div_mode,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_part,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_part
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_borrow;

  always_comb begin
    w_sum    = {1'b0, i_acc} + (i_part[0] ? {1'b0, i_opnd} : '0);
    w_shift  = {i_acc, i_part[XLEN-1]};
    w_diff   = w_shift - {1'b0, i_opnd};
    // Remainder stays below the divisor, so the top diff bit is a clean borrow flag.
    w_borrow = w_diff[XLEN];
    if (i_div_mode) begin
      o_acc  = w_borrow ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
      o_part = {i_part[XLEN-2:0], ~w_borrow};
    end else begin
      o_acc  = w_sum[XLEN:1];
      o_part = {w_sum[0], i_part[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Purpose: iterative RV32M multiply/divide unit feeding the GPR write port.
// Ports:   clk, rst          - clock, synchronous active-high reset
//          start, kill       - op request (sampled when idle), flush
//          funct3            - RV32M operation
//          rs1_data/rs2_data - operands A and B
//          rd_addr           - destination register, captured with start
//          busy              - op in flight (accept edge through write-back)
//          wb_enable/addr/data - single-cycle GPR write-back beat
module muldiv_unit
  import rv32m_defs::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [RF_AW-1:0] rd_addr,
  output logic             busy,
  output logic             wb_enable,
  output logic [RF_AW-1:0] wb_addr,
  output logic [XLEN-1:0]  wb_data
);

  localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t           r_state,   w_state_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [2:0]       r_f3,      w_f3_nxt;
  logic [RF_AW-1:0] r_rd,      w_rd_nxt;
  logic [XLEN-1:0]  r_acc,     w_acc_nxt;
  logic [XLEN-1:0]  r_part,    w_part_nxt;
  logic [XLEN-1:0]  r_opnd,    w_opnd_nxt;
  logic             r_neg_res, w_neg_res_nxt;
  logic             r_neg_rem, w_neg_rem_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_wb_en,   w_wb_en_nxt;
  logic [RF_AW-1:0] r_wb_addr, w_wb_addr_nxt;
  logic [XLEN-1:0]  r_wb_data, w_wb_data_nxt;

  logic              w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic              w_div0, w_ovf;
  logic [XLEN-1:0]   w_special;
  logic [XLEN-1:0]   w_step_acc, w_step_part;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0]   w_quot, w_rem, w_result;

  // Operand signedness and magnitudes of the incoming request.
  assign w_sgn_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign w_sgn_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign w_neg_a = w_sgn_a & rs1_data[XLEN-1];
  assign w_neg_b = w_sgn_b & rs2_data[XLEN-1];
  assign w_mag_a = w_neg_a ? (~rs1_data + XLEN'(1)) : rs1_data;
  assign w_mag_b = w_neg_b ? (~rs2_data + XLEN'(1)) : rs2_data;

  // Divide special cases resolved at accept time.
  assign w_div0 = funct3[2] && (rs2_data == '0);
  assign w_ovf  = funct3[2] && !funct3[0] && (rs1_data == XLEN_MIN) && (rs2_data == '1);

  always_comb begin
    if (w_div0) w_special = funct3[1] ? rs1_data : '1;
    else        w_special = funct3[1] ? '0 : XLEN_MIN;
  end

  muldiv_step u_step (
    .i_div_mode (r_f3[2]),
    .i_acc      (r_acc),
    .i_part     (r_part),
    .i_opnd     (r_opnd),
    .o_acc      (w_step_acc),
    .o_part     (w_step_part)
  );

  // Sign fix-up and result select applied to the final iteration's output.
  always_comb begin
    w_prod     = {w_step_acc, w_step_part};
    w_prod_fix = r_neg_res ? (~w_prod + (2*XLEN)'(1)) : w_prod;
    w_quot     = r_neg_res ? (~w_step_part + XLEN'(1)) : w_step_part;
    w_rem      = r_neg_rem ? (~w_step_acc + XLEN'(1)) : w_step_acc;
    if (r_f3[2])             w_result = r_f3[1] ? w_rem : w_quot;
    else if (r_f3 == F3_MUL) w_result = w_prod_fix[XLEN-1:0];
    else                     w_result = w_prod_fix[2*XLEN-1:XLEN];
  end

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_f3_nxt      = r_f3;
    w_rd_nxt      = r_rd;
    w_acc_nxt     = r_acc;
    w_part_nxt    = r_part;
    w_opnd_nxt    = r_opnd;
    w_neg_res_nxt = r_neg_res;
    w_neg_rem_nxt = r_neg_rem;
    w_busy_nxt    = r_busy;
    w_wb_en_nxt   = 1'b0;
    w_wb_addr_nxt = r_wb_addr;
    w_wb_data_nxt = r_wb_data;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_f3_nxt      = funct3;
          w_rd_nxt      = rd_addr;
          w_cnt_nxt     = '0;
          w_acc_nxt     = '0;
          // Multiply is commutative, so A/B slot the same way for both modes.
          w_part_nxt    = w_mag_a;
          w_opnd_nxt    = w_mag_b;
          w_neg_res_nxt = w_neg_a ^ w_neg_b;
          w_neg_rem_nxt = w_neg_a;
          w_busy_nxt    = 1'b1;
          if (w_div0 || w_ovf) begin
            w_state_nxt   = DONE;
            w_wb_en_nxt   = 1'b1;
            w_wb_addr_nxt = rd_addr;
            w_wb_data_nxt = w_special;
          end else begin
            w_state_nxt   = CALC;
          end
        end
      end
      CALC: begin
        w_acc_nxt  = w_step_acc;
        w_part_nxt = w_step_part;
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(ITERS - 1)) begin
          w_state_nxt   = DONE;
          w_wb_en_nxt   = 1'b1;
          w_wb_addr_nxt = r_rd;
          w_wb_data_nxt = w_result;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Flush overrides everything; write-back registers keep their old beat.
    if (kill) begin
      w_state_nxt   = IDLE;
      w_busy_nxt    = 1'b0;
      w_wb_en_nxt   = 1'b0;
      w_wb_addr_nxt = r_wb_addr;
      w_wb_data_nxt = r_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_f3      <= '0;
      r_rd      <= '0;
      r_acc     <= '0;
      r_part    <= '0;
      r_opnd    <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_f3      <= w_f3_nxt;
      r_rd      <= w_rd_nxt;
      r_acc     <= w_acc_nxt;
      r_part    <= w_part_nxt;
      r_opnd    <= w_opnd_nxt;
      r_neg_res <= w_neg_res_nxt;
      r_neg_rem <= w_neg_rem_nxt;
      r_busy    <= w_busy_nxt;
      r_wb_en   <= w_wb_en_nxt;
      r_wb_addr <= w_wb_addr_nxt;
      r_wb_data <= w_wb_data_nxt;
    end
  end

  assign busy      = r_busy;
  // A flush in the write-back cycle must suppress the strobe in that same cycle.
  assign wb_enable = r_wb_en & ~kill;
  assign wb_addr   = r_wb_addr;
  assign wb_data   = r_wb_data;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        busy, wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .kill      (kill),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .wb_enable (wb_enable),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_addr = rd;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Issue an op and observe its write-back; lat = edges after the accept edge (-1 if none).
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output logic [31:0] data,
                       output logic [4:0] addr, output logic busy_at, output logic busy_after,
                       output logic wb_after);
    lat = -1; data = '0; addr = '0; busy_at = 1'b0;
    issue(f3, a, b, rd);
    for (int k = 0; k <= 40; k++) begin
      if (wb_enable === 1'b1) begin
        lat = k; data = wb_data; addr = wb_addr; busy_at = busy;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    busy_after = busy;
    wb_after   = wb_enable;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, expected 0", busy); end
    n_tests++; if (wb_enable !== 1'b0) begin n_fail++; $display("FAIL reset wb_enable: got %b, expected 0", wb_enable); end
    n_tests++; if (wb_addr !== 5'd0) begin n_fail++; $display("FAIL reset wb_addr: got %h, expected 0", wb_addr); end
    n_tests++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL reset wb_data: got %h, expected 0", wb_data); end
  endtask

  task automatic test_mul_latency();
    int lat; logic [31:0] d; logic [4:0] ad; logic ba, bf, wa;
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, lat, d, ad, ba, bf, wa);
    n_tests++; if (lat !== 32) begin n_fail++; $display("FAIL mul latency: got %0d, expected 32", lat); end
    n_tests++; if (d !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul data: got %h, expected ffffffeb", d); end
    n_tests++; if (ad !== 5'd5) begin n_fail++; $display("FAIL mul addr: got %0d, expected 5", ad); end
    n_tests++; if (ba !== 1'b1) begin n_fail++; $display("FAIL mul busy at wb: got %b, expected 1", ba); end
    n_tests++; if (bf !== 1'b0) begin n_fail++; $display("FAIL mul busy after wb: got %b, expected 0", bf); end
    n_tests++; if (wa !== 1'b0) begin n_fail++; $display("FAIL mul wb width: got %b, expected 0", wa); end
  endtask

  task automatic test_mul_high();
    logic [2:0]  f3  [5] = '{3'b011, 3'b010, 3'b001, 3'b001, 3'b000};
    logic [31:0] a   [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
    logic [31:0] b   [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd2, 32'd3};
    logic [31:0] exp [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'h8000_0003};
    int lat; logic [31:0] d; logic [4:0] ad; logic ba, bf, wa;
    for (int i = 0; i < 5; i++) begin
      do_op(f3[i], a[i], b[i], 5'(i + 10), lat, d, ad, ba, bf, wa);
      n_tests++; if (d !== exp[i]) begin n_fail++; $display("FAIL mulh[%0d] data: got %h, expected %h", i, d, exp[i]); end
      n_tests++; if (lat !== 32) begin n_fail++; $display("FAIL mulh[%0d] latency: got %0d, expected 32", i, lat); end
      n_tests++; if (ad !== 5'(i + 10)) begin n_fail++; $display("FAIL mulh[%0d] addr: got %0d, expected %0d", i, ad, i + 10); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3  [7] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101};
    logic [31:0] a   [7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd20, 32'd20, 32'd9};
    logic [31:0] b   [7] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3};
    logic [31:0] exp [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFA, 32'd2, 32'd3};
    logic [4:0]  rd  [7] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd0};
    int lat; logic [31:0] d; logic [4:0] ad; logic ba, bf, wa;
    for (int i = 0; i < 7; i++) begin
      do_op(f3[i], a[i], b[i], rd[i], lat, d, ad, ba, bf, wa);
      n_tests++; if (d !== exp[i]) begin n_fail++; $display("FAIL div[%0d] data: got %h, expected %h", i, d, exp[i]); end
      n_tests++; if (lat !== 32) begin n_fail++; $display("FAIL div[%0d] latency: got %0d, expected 32", i, lat); end
      n_tests++; if (ad !== rd[i]) begin n_fail++; $display("FAIL div[%0d] addr: got %0d, expected %0d", i, ad, rd[i]); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3  [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] a   [4] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};
    int lat; logic [31:0] d; logic [4:0] ad; logic ba, bf, wa;
    for (int i = 0; i < 4; i++) begin
      do_op(f3[i], a[i], b[i], 5'(i + 20), lat, d, ad, ba, bf, wa);
      n_tests++; if (d !== exp[i]) begin n_fail++; $display("FAIL special[%0d] data: got %h, expected %h", i, d, exp[i]); end
      n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL special[%0d] latency: got %0d, expected 0", i, lat); end
      n_tests++; if (ba !== 1'b1) begin n_fail++; $display("FAIL special[%0d] busy at wb: got %b, expected 1", i, ba); end
      n_tests++; if (bf !== 1'b0) begin n_fail++; $display("FAIL special[%0d] busy after: got %b, expected 0", i, bf); end
    end
  endtask

  task automatic test_rst_mid();
    int nwb = 0;
    issue(3'b100, 32'd100, 32'd7, 5'd8);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy: got %b, expected 0", busy); end
    n_tests++; if (wb_addr !== 5'd0) begin n_fail++; $display("FAIL rst_mid wb_addr: got %0d, expected 0", wb_addr); end
    n_tests++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL rst_mid wb_data: got %h, expected 0", wb_data); end
    for (int k = 0; k < 40; k++) begin
      if (wb_enable === 1'b1) nwb++;
      @(negedge clk);
    end
    n_tests++; if (nwb !== 0) begin n_fail++; $display("FAIL rst_mid writebacks: got %0d, expected 0", nwb); end
  endtask

  task automatic test_kill_calc();
    int nwb = 0;
    issue(3'b100, 32'd100, 32'd7, 5'd8);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_calc busy: got %b, expected 0", busy); end
    for (int k = 0; k < 40; k++) begin
      if (wb_enable === 1'b1) nwb++;
      @(negedge clk);
    end
    n_tests++; if (nwb !== 0) begin n_fail++; $display("FAIL kill_calc writebacks: got %0d, expected 0", nwb); end
  endtask

  task automatic test_kill_done();
    int nwb = 0;
    issue(3'b000, 32'd6, 32'd7, 5'd4);
    repeat (32) @(negedge clk);
    kill = 1'b1;
    #1;
    n_tests++; if (wb_enable !== 1'b0) begin n_fail++; $display("FAIL kill_done wb_enable: got %b, expected 0", wb_enable); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL kill_done busy in done: got %b, expected 1", busy); end
    @(negedge clk);
    kill = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_done busy after: got %b, expected 0", busy); end
    for (int k = 0; k < 40; k++) begin
      if (wb_enable === 1'b1) nwb++;
      @(negedge clk);
    end
    n_tests++; if (nwb !== 0) begin n_fail++; $display("FAIL kill_done writebacks: got %0d, expected 0", nwb); end
  endtask

  task automatic test_start_kill_idle();
    int nwb = 0;
    kill = 1'b1;
    issue(3'b101, 32'd100, 32'd7, 5'd9);
    kill = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_kill busy: got %b, expected 0", busy); end
    for (int k = 0; k < 40; k++) begin
      if (wb_enable === 1'b1) nwb++;
      @(negedge clk);
    end
    n_tests++; if (nwb !== 0) begin n_fail++; $display("FAIL start_kill writebacks: got %0d, expected 0", nwb); end
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1, nwb = 0;
    logic [31:0] d1 = '0, d2 = '0;
    logic [4:0]  a1 = '0, a2 = '0;
    issue(3'b000, 32'd6, 32'd7, 5'd3);
    repeat (9) @(negedge clk);
    issue(3'b101, 32'd100, 32'd7, 5'd9);
    for (int k = 0; k < 40; k++) begin
      if (wb_enable === 1'b1) begin t1 = cyc; d1 = wb_data; a1 = wb_addr; break; end
      @(negedge clk);
    end
    @(negedge clk);
    issue(3'b101, 32'd100, 32'd7, 5'd9);
    for (int k = 0; k < 40; k++) begin
      if (wb_enable === 1'b1) begin
        nwb++;
        if (t2 < 0) begin t2 = cyc; d2 = wb_data; a2 = wb_addr; end
      end
      @(negedge clk);
    end
    n_tests++; if (d1 !== 32'd42) begin n_fail++; $display("FAIL b2b first data: got %h, expected 0000002a", d1); end
    n_tests++; if (a1 !== 5'd3) begin n_fail++; $display("FAIL b2b first addr: got %0d, expected 3", a1); end
    n_tests++; if (d2 !== 32'd14) begin n_fail++; $display("FAIL b2b second data: got %h, expected 0000000e", d2); end
    n_tests++; if (a2 !== 5'd9) begin n_fail++; $display("FAIL b2b second addr: got %0d, expected 9", a2); end
    n_tests++; if (t2 - t1 !== 34) begin n_fail++; $display("FAIL b2b spacing: got %0d, expected 34", t2 - t1); end
    n_tests++; if (nwb !== 1) begin n_fail++; $display("FAIL b2b second pulse count: got %0d, expected 1", nwb); end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_mul_high();
    test_div();
    test_special();
    test_rst_mid();
    test_kill_calc();
    test_kill_done();
    test_start_kill_idle();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
